io_func_mux: RTL and testbench
==============================

# io_func_mux

Wishbone-programmable pad function multiplexer between the SoC peripherals and the user-area GPIO pads. It replaces fixed pin assignment: every pad selects one of four peripheral functions at run time. It also synchronises pad inputs, routes them back to the selected function, and raises a rising-edge interrupt per pad. It sits in the user project wrapper between the Wishbone slave port, the core's peripheral pins and `io_in`/`io_out`/`io_oeb`.

## Interface
- `NUM_IO`, 38: number of pads, 1..64.
- `RESET_SEL`, {2*NUM_IO{1'b0}}: per-pad function select loaded at reset; pad p uses bits [2p+1:2p].
- `IN_IDLE`, 1'b1: value driven on a function input whose pad is not routed to it.
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  asynchronous, active-high reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone classic strobe, cycle and write enable.
- `wbs_sel_i`  in  4  byte enables.
- `wbs_adr_i`  in  32  byte address; only [5:2] are decoded.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  transfer acknowledge.
- `wbs_dat_o`  out  32  read data.
- `fn_out_i`  in  4*NUM_IO  peripheral outputs; function f, pad p at bit f*NUM_IO+p.
- `fn_oeb_i`  in  4*NUM_IO  peripheral output enables, active-low, same packing.
- `fn_in_o`  out  4*NUM_IO  synchronised pad input per function, same packing.
- `io_in`  in  NUM_IO  pad inputs (asynchronous).
- `io_out`  out  NUM_IO  pad outputs.
- `io_oeb`  out  NUM_IO  pad output enables, active-low.
- `irq_o`  out  1  level interrupt.

## Operation
- Register map by word offset (adr[5:2]):
  - 0x00–0x0C: SEL0..SEL3. Pad p is held in word p/16, bits 2(p%16)+1:2(p%16). Bits for nonexistent pads read 0.
  - 0x10: LOCK, bit0. Write 1 to set; it can only be cleared by reset. While set, writes to SEL are ignored.
  - 0x20/0x24: IN_LO/IN_HI, read-only synchronised pad levels for pads 0–31 / 32–63.
  - 0x28/0x2C: IEN_LO/IEN_HI, interrupt enables.
  - 0x30/0x34: IST_LO/IST_HI, interrupt status. Writing 1 clears a bit (W1C).
- Byte enables gate writes to SEL, IEN and IST. LOCK uses byte 0.
- Unmapped offsets read 0, ignore writes, and still acknowledge.
- Output mux (combinational):
  - io_out[p] = fn_out_i[sel_p*NUM_IO+p]
  - io_oeb[p] = fn_oeb_i[sel_p*NUM_IO+p]
- Input path:
  - Two-flop synchroniser per pad produces `sync[p]`.
  - fn_in_o[f*NUM_IO+p] = (sel_p==f) ? sync[p] : IN_IDLE.
- Edge detect: a third flop `prev[p]` holds the previous value. A rise is `sync & ~prev`.
  - A rise sets IST[p] whether or not IEN[p] is set.
  - If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- irq_o is a register of |(IST & IEN).

## Timing
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
  - SEL=RESET_SEL, LOCK=0, IEN=0, IST=0.
  - sync and prev chains all 1, so pads that idle high produce no spurious edge.
- Wishbone:
  - wbs_ack_o rises on the edge after stb&cyc is sampled with ack low. It stays high for exactly one cycle.
  - A held strobe therefore completes one transfer every 2 cycles.
  - Read data is registered and valid while ack is high. wbs_dat_o returns to 0 when ack is low.
- A register write takes effect on the same edge that raises ack. The mux and enables reflect the new value during the ack cycle.
- Pad-to-fn_in_o latency is 2 cycles.
- Pad rise to IST bit set is 3 edges. irq_o follows 1 edge later.
- Clearing IST or IEN drops irq_o 1 cycle after the ack cycle.
- An asynchronous reset mid-transfer drops ack immediately. The master must retry.

## Test plan
- Reset with RESET_SEL=0 and fn_out_i function 0 = 38'h15_5555_5555: io_out must equal 38'h15_5555_5555, every output is at its reset value, and a read of SEL0 returns 0.
- Write SEL0=0x0000_000C (pad1→function 3), then drive fn_out_i[3*38+1]=1 with fn_oeb_i[3*38+1]=0. In the ack cycle io_out[1]=1 and io_oeb[1]=0, and fn_in_o[0*38+1] equals IN_IDLE.
- Write LOCK=1, then SEL0=0xFFFF_FFFF: the write is acknowledged, a readback still shows 0x0000_000C, and pad routing is unchanged.
- Set IEN_LO bit5 and drive io_in[5] 1→0→1. IST_LO bit5 sets 3 cycles after the rise and irq_o rises 1 cycle later. Writing IST_LO=0x20 clears both.
- Apply a rise on pad 5 in the same cycle as a W1C write to bit 5: IST bit5 stays 1.
- Assert wb_rst_i during an outstanding read: ack drops asynchronously and all registers return to their reset values.

Source files
------------

// File: rtl/io_func_mux.sv
// io_func_mux: Wishbone-programmable pad function multiplexer.
// Each pad selects one of four peripheral functions for its output and output
// enable, and its synchronised input is routed back to the selected function
// only. Rising edges on pad inputs latch per-pad interrupt status bits.
module io_func_mux #(
  parameter int unsigned         NUM_IO    = 38,
  parameter logic [2*NUM_IO-1:0] RESET_SEL = '0,
  parameter logic                IN_IDLE   = 1'b1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  input  logic [4*NUM_IO-1:0]   fn_out_i,
  input  logic [4*NUM_IO-1:0]   fn_oeb_i,
  output logic [4*NUM_IO-1:0]   fn_in_o,
  input  logic [NUM_IO-1:0]     io_in,
  output logic [NUM_IO-1:0]     io_out,
  output logic [NUM_IO-1:0]     io_oeb,
  output logic                  irq_o
);

  // Word offsets (adr[5:2])
  localparam logic [3:0] AdrLock  = 4'h4;
  localparam logic [3:0] AdrInLo  = 4'h8;
  localparam logic [3:0] AdrInHi  = 4'h9;
  localparam logic [3:0] AdrIenLo = 4'hA;
  localparam logic [3:0] AdrIenHi = 4'hB;
  localparam logic [3:0] AdrIstLo = 4'hC;
  localparam logic [3:0] AdrIstHi = 4'hD;

  // Register state
  logic [2*NUM_IO-1:0] sel_q, sel_d;
  logic                lock_q, lock_d;
  logic [NUM_IO-1:0]   ien_q, ien_d;
  logic [NUM_IO-1:0]   ist_q, ist_d;
  logic                ack_q;
  logic [31:0]         rdata_q, rdata_d;
  logic                irq_q;

  // Input synchroniser and edge detector
  logic [NUM_IO-1:0]   sync1_q, sync_q, prev_q;
  logic [NUM_IO-1:0]   rise;

  // Bus decode
  logic                req;
  logic                wr;
  logic [3:0]          word;
  logic [31:0]         bmask;
  logic [31:0]         rd_mux;

  // Zero-padded views so the register map can be indexed as full 32-bit words
  logic [127:0]        sel_pad, sel_wide;
  logic [63:0]         sync_pad, ien_pad, ist_pad, ien_wide, clr_wide;

  // Address bits outside [5:2] are not decoded
  logic                unused_adr;
  assign unused_adr = ^{wbs_adr_i[31:6], wbs_adr_i[1:0]};

  // A new transfer starts only while ack is low, so a held strobe completes
  // one transfer every two cycles.
  assign req   = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign wr    = req & wbs_we_i;
  assign word  = wbs_adr_i[5:2];
  assign bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign rise  = sync_q & ~prev_q;

  // Widen narrow registers to the full register-map width
  always_comb begin
    sel_pad  = '0;
    sync_pad = '0;
    ien_pad  = '0;
    ist_pad  = '0;
    sel_pad[2*NUM_IO-1:0] = sel_q;
    sync_pad[NUM_IO-1:0]  = sync_q;
    ien_pad[NUM_IO-1:0]   = ien_q;
    ist_pad[NUM_IO-1:0]   = ist_q;
  end

  // SEL next state: byte-gated write, blocked while locked
  always_comb begin
    sel_wide = sel_pad;
    if (wr && !lock_q && (word[3:2] == 2'b00)) begin
      sel_wide[{word[1:0], 5'd0} +: 32] =
        (sel_pad[{word[1:0], 5'd0} +: 32] & ~bmask) | (wbs_dat_i & bmask);
    end
    sel_d = sel_wide[2*NUM_IO-1:0];
  end

  // LOCK next state: sticky until reset
  always_comb begin
    lock_d = lock_q;
    if (wr && (word == AdrLock) && wbs_sel_i[0] && wbs_dat_i[0]) begin
      lock_d = 1'b1;
    end
  end

  // IEN next state: byte-gated write, bits for absent pads dropped
  always_comb begin
    ien_wide = ien_pad;
    if (wr && ((word == AdrIenLo) || (word == AdrIenHi))) begin
      ien_wide[{word[0], 5'd0} +: 32] =
        (ien_pad[{word[0], 5'd0} +: 32] & ~bmask) | (wbs_dat_i & bmask);
    end
    ien_d = ien_wide[NUM_IO-1:0];
  end

  // IST next state: W1C clear, then a rise sets so a same-cycle set wins
  always_comb begin
    clr_wide = '0;
    if (wr && ((word == AdrIstLo) || (word == AdrIstHi))) begin
      clr_wide[{word[0], 5'd0} +: 32] = wbs_dat_i & bmask;
    end
    ist_d = (ist_q & ~clr_wide[NUM_IO-1:0]) | rise;
  end

  // Read data multiplexer (sampled into the registered read data)
  always_comb begin
    rd_mux = '0;
    case (word)
      4'h0, 4'h1, 4'h2, 4'h3: rd_mux = sel_pad[{word[1:0], 5'd0} +: 32];
      AdrLock:                rd_mux = {31'd0, lock_q};
      AdrInLo:                rd_mux = sync_pad[31:0];
      AdrInHi:                rd_mux = sync_pad[63:32];
      AdrIenLo:               rd_mux = ien_pad[31:0];
      AdrIenHi:               rd_mux = ien_pad[63:32];
      AdrIstLo:               rd_mux = ist_pad[31:0];
      AdrIstHi:               rd_mux = ist_pad[63:32];
      default:                rd_mux = '0;
    endcase
  end

  // Read data is only non-zero during the ack cycle
  always_comb begin
    rdata_d = req ? rd_mux : 32'd0;
  end

  // Bus, register and interrupt state
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      sel_q   <= RESET_SEL;
      lock_q  <= 1'b0;
      ien_q   <= '0;
      ist_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      ack_q   <= req;
      rdata_q <= rdata_d;
      sel_q   <= sel_d;
      lock_q  <= lock_d;
      ien_q   <= ien_d;
      ist_q   <= ist_d;
      irq_q   <= |(ist_q & ien_q);
    end
  end

  // Pad input synchroniser plus previous-value flop; reset high so idle-high
  // pads do not produce a spurious rise when reset is released.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_q <= '1;
      sync_q  <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= io_in;
      sync_q  <= sync1_q;
      prev_q  <= sync_q;
    end
  end

  // Output mux: each pad drives the selected function's output and enable
  always_comb begin
    io_out = '0;
    io_oeb = '1;
    for (int p = 0; p < NUM_IO; p++) begin
      case (sel_q[2*p +: 2])
        2'd0: begin
          io_out[p] = fn_out_i[p];
          io_oeb[p] = fn_oeb_i[p];
        end
        2'd1: begin
          io_out[p] = fn_out_i[NUM_IO + p];
          io_oeb[p] = fn_oeb_i[NUM_IO + p];
        end
        2'd2: begin
          io_out[p] = fn_out_i[2*NUM_IO + p];
          io_oeb[p] = fn_oeb_i[2*NUM_IO + p];
        end
        default: begin
          io_out[p] = fn_out_i[3*NUM_IO + p];
          io_oeb[p] = fn_oeb_i[3*NUM_IO + p];
        end
      endcase
    end
  end

  // Input routing: only the selected function sees the pad, others idle
  always_comb begin
    fn_in_o = '0;
    for (int f = 0; f < 4; f++) begin
      for (int p = 0; p < NUM_IO; p++) begin
        fn_in_o[f*NUM_IO + p] = (sel_q[2*p +: 2] == 2'(f)) ? sync_q[p] : IN_IDLE;
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rdata_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_io_func_mux.sv
// Bench for io_func_mux: scenario tasks with a read-data scoreboard queue.
module tb_io_func_mux;

  localparam int N = 38;

  logic           clk;
  logic           rst;
  logic           stb, cyc, we;
  logic [3:0]     bsel;
  logic [31:0]    adr, dat_w;
  logic           ack;
  logic [31:0]    dat_r;
  logic [4*N-1:0] fn_out, fn_oeb, fn_in;
  logic [N-1:0]   io_in, io_out, io_oeb;
  logic           irq;

  int             n_tests;
  int             n_fail;
  logic [31:0]    exp_q[$];

  io_func_mux #(
    .NUM_IO   (N),
    .RESET_SEL({2*N{1'b0}}),
    .IN_IDLE  (1'b1)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(bsel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat_w),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_r),
    .fn_out_i (fn_out),
    .fn_oeb_i (fn_oeb),
    .fn_in_o  (fn_in),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge of the ack cycle.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic [31:0] rd, output logic got);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_w = d; bsel = be;
    got = 1'b0;
    rd  = '0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ack) begin
        got = 1'b1;
        rd  = dat_r;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL wb_ack adr=%h: got no ack, required ack within 8 cycles", a);
    end
  endtask

  task automatic test_reset();
    logic [31:0] adr_tab [6];
    logic [31:0] rd, e;
    logic        got;
    rst = 1'b1; stb = 0; cyc = 0; we = 0; bsel = 0; adr = 0; dat_w = 0;
    fn_out = '0;
    fn_out[N-1:0] = 38'h15_5555_5555;
    fn_oeb = '1;
    io_in  = '1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (io_out !== 38'h15_5555_5555) begin
      n_fail++; $display("FAIL reset_io_out: got %h, required %h", io_out, 38'h15_5555_5555);
    end
    n_tests++;
    if (io_oeb !== {N{1'b1}}) begin
      n_fail++; $display("FAIL reset_io_oeb: got %h, required all ones", io_oeb);
    end
    n_tests++;
    if (ack !== 1'b0 || dat_r !== 32'd0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got ack=%b dat=%h irq=%b, required 0 0 0", ack, dat_r, irq);
    end
    n_tests++;
    if (fn_in !== {4*N{1'b1}}) begin
      n_fail++; $display("FAIL reset_fn_in: got %h, required all ones", fn_in);
    end
    rst = 1'b0;
    @(negedge clk);
    // SEL0, LOCK, IEN_LO, IST_LO, unmapped, IN_HI
    adr_tab = '{32'h00, 32'h10, 32'h28, 32'h30, 32'h18, 32'h24};
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h3F);
    for (int i = 0; i < 6; i++) begin
      wb_xfer(1'b0, adr_tab[i], 32'h0, 4'hF, rd, got);
      e = exp_q.pop_front();
      n_tests++;
      if (rd !== e) begin
        n_fail++; $display("FAIL reset_read adr=%h: got %h, required %h", adr_tab[i], rd, e);
      end
    end
  endtask

  task automatic test_route();
    logic [31:0] adr_tab [4];
    logic [31:0] rd, e;
    logic        got;
    io_in[1] = 1'b0;
    fn_out[3*N+1] = 1'b1;
    fn_oeb[3*N+1] = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (io_out[1] !== 1'b0) begin
      n_fail++; $display("FAIL route_before: got io_out[1]=%b, required 0", io_out[1]);
    end
    wb_xfer(1'b1, 32'h00, 32'h0000_000C, 4'hF, rd, got);
    n_tests++;
    if (io_out[1] !== 1'b1 || io_oeb[1] !== 1'b0) begin
      n_fail++; $display("FAIL route_out: got out=%b oeb=%b, required 1 0", io_out[1], io_oeb[1]);
    end
    n_tests++;
    if (fn_in[1] !== 1'b1 || fn_in[3*N+1] !== 1'b0) begin
      n_fail++; $display("FAIL route_in: got f0=%b f3=%b, required 1 0", fn_in[1], fn_in[3*N+1]);
    end
    // Only byte 0 enabled: upper bytes must not land
    wb_xfer(1'b1, 32'h00, 32'h1234_560C, 4'b0001, rd, got);
    // Pads 32..37 to function 3; bits for absent pads must read 0
    wb_xfer(1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF, rd, got);
    n_tests++;
    if (io_out[37:32] !== 6'h00) begin
      n_fail++; $display("FAIL route_hi_pads: got %h, required 00", io_out[37:32]);
    end
    adr_tab = '{32'h00, 32'h08, 32'h0C, 32'h20};
    exp_q.push_back(32'h0000_000C); exp_q.push_back(32'h0000_0FFF);
    exp_q.push_back(32'h0);         exp_q.push_back(32'hFFFF_FFFD);
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b0, adr_tab[i], 32'h0, 4'hF, rd, got);
      e = exp_q.pop_front();
      n_tests++;
      if (rd !== e) begin
        n_fail++; $display("FAIL route_read adr=%h: got %h, required %h", adr_tab[i], rd, e);
      end
    end
    wb_xfer(1'b1, 32'h08, 32'h0, 4'hF, rd, got);
    n_tests++;
    if (io_out[37:32] !== 6'h15) begin
      n_fail++; $display("FAIL route_hi_restore: got %h, required 15", io_out[37:32]);
    end
  endtask

  task automatic test_lock();
    logic [31:0] rd, e;
    logic        got;
    wb_xfer(1'b1, 32'h10, 32'h1, 4'hF, rd, got);
    exp_q.push_back(32'h1);
    wb_xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, got);
    e = exp_q.pop_front();
    n_tests++;
    if (rd !== e) begin
      n_fail++; $display("FAIL lock_read: got %h, required %h", rd, e);
    end
    wb_xfer(1'b1, 32'h00, 32'hFFFF_FFFF, 4'hF, rd, got);
    n_tests++;
    if (io_out[0] !== 1'b1 || io_out[1] !== 1'b1) begin
      n_fail++; $display("FAIL lock_route: got io_out[1:0]=%b, required 11", io_out[1:0]);
    end
    exp_q.push_back(32'h0000_000C);
    wb_xfer(1'b0, 32'h00, 32'h0, 4'hF, rd, got);
    e = exp_q.pop_front();
    n_tests++;
    if (rd !== e) begin
      n_fail++; $display("FAIL lock_sel0: got %h, required %h", rd, e);
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd, e;
    logic        got;
    logic        exp_fin [4];
    logic        exp_irq [4];
    wb_xfer(1'b1, 32'h28, 32'h20, 4'hF, rd, got);
    io_in[5] = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_fall: got %b, required 0", irq);
    end
    io_in[5] = 1'b1;
    exp_fin = '{1'b0, 1'b1, 1'b1, 1'b1};
    exp_irq = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if (fn_in[5] !== exp_fin[i] || irq !== exp_irq[i]) begin
        n_fail++;
        $display("FAIL irq_timing edge %0d: got fn_in=%b irq=%b, required %b %b",
                 i + 1, fn_in[5], irq, exp_fin[i], exp_irq[i]);
      end
    end
    exp_q.push_back(32'h20);
    wb_xfer(1'b0, 32'h30, 32'h0, 4'hF, rd, got);
    e = exp_q.pop_front();
    n_tests++;
    if (rd !== e) begin
      n_fail++; $display("FAIL irq_ist_set: got %h, required %h", rd, e);
    end
    wb_xfer(1'b1, 32'h30, 32'h20, 4'hF, rd, got);
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL irq_ack_cycle: got %b, required 1", irq);
    end
    @(negedge clk);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_cleared: got %b, required 0", irq);
    end
    exp_q.push_back(32'h0);
    wb_xfer(1'b0, 32'h30, 32'h0, 4'hF, rd, got);
    e = exp_q.pop_front();
    n_tests++;
    if (rd !== e) begin
      n_fail++; $display("FAIL irq_ist_clr: got %h, required %h", rd, e);
    end
  endtask

  task automatic test_set_wins();
    logic [31:0] rd, e;
    logic        got;
    io_in[5] = 1'b0;
    repeat (4) @(negedge clk);
    io_in[5] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    // The W1C lands on the third edge after the rise, together with the set
    wb_xfer(1'b1, 32'h30, 32'h20, 4'hF, rd, got);
    exp_q.push_back(32'h20);
    wb_xfer(1'b0, 32'h30, 32'h0, 4'hF, rd, got);
    e = exp_q.pop_front();
    n_tests++;
    if (rd !== e) begin
      n_fail++; $display("FAIL set_wins: got %h, required %h", rd, e);
    end
    wb_xfer(1'b1, 32'h30, 32'h20, 4'hF, rd, got);
    exp_q.push_back(32'h0);
    wb_xfer(1'b0, 32'h30, 32'h0, 4'hF, rd, got);
    e = exp_q.pop_front();
    n_tests++;
    if (rd !== e) begin
      n_fail++; $display("FAIL set_wins_reclear: got %h, required %h", rd, e);
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_ack;
    logic [31:0] e;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h00; bsel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_ack = (i % 2 == 0);
      exp_q.push_back(exp_ack ? 32'h0000_000C : 32'h0);
      e = exp_q.pop_front();
      n_tests++;
      if (ack !== exp_ack || dat_r !== e) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got ack=%b dat=%h, required %b %h",
                 i, ack, dat_r, exp_ack, e);
      end
    end
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] adr_tab [4];
    logic [31:0] rd, e;
    logic        got;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'h00; bsel = 4'hF;
    @(posedge clk);
    #1;
    n_tests++;
    if (ack !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_pre: got ack=%b, required 1", ack);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (ack !== 1'b0 || dat_r !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_async: got ack=%b dat=%h, required 0 0", ack, dat_r);
    end
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    n_tests++;
    if (io_out[1] !== 1'b0 || io_oeb[1] !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_route: got out=%b oeb=%b, required 0 1", io_out[1], io_oeb[1]);
    end
    rst = 1'b0;
    @(negedge clk);
    adr_tab = '{32'h00, 32'h10, 32'h28, 32'h30};
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b0, adr_tab[i], 32'h0, 4'hF, rd, got);
      e = exp_q.pop_front();
      n_tests++;
      if (rd !== e) begin
        n_fail++; $display("FAIL reset_mid_read adr=%h: got %h, required %h", adr_tab[i], rd, e);
      end
    end
    // Lock is cleared, so SEL is writable again
    wb_xfer(1'b1, 32'h00, 32'h0000_0004, 4'hF, rd, got);
    exp_q.push_back(32'h0000_0004);
    wb_xfer(1'b0, 32'h00, 32'h0, 4'hF, rd, got);
    e = exp_q.pop_front();
    n_tests++;
    if (rd !== e) begin
      n_fail++; $display("FAIL reset_mid_unlock: got %h, required %h", rd, e);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_route();
    test_lock();
    test_irq();
    test_set_wins();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
